// File: rtl/shiftreg_seq.sv
// ---------------------------------------------------------------------------
// shiftreg_seq
//   Multi-cycle universal shift register. A start in IDLE loads the parallel
//   word I and latches mode/dir/amt. The word is then shifted one position per
//   clock for amt steps, and done pulses for one cycle.
//
//   Modes: 00 logical, 01 arithmetic, 10 rotate, 11 serial fill from din.
//   dir: 1 = shift left (toward MSB), 0 = shift right.
//
//   Handshake (valid/ready): start is the request valid. It is accepted only
//   on an edge where the FSM is in IDLE, so IDLE is the implicit ready. start
//   is ignored in SHIFT and DONE, and nothing is queued. Inputs sampled at
//   acceptance are held internally, so later changes to I/mode/dir/amt do
//   nothing. din is the exception: serial mode samples it live on every shift
//   edge. busy is high while shifting. done is a one-cycle pulse, and Q is
//   final while done is high.
//
//   Configuration macro: SHIFTREG_ROTATE_EN
//     defined   : mode 10 rotates (the exiting bit re-enters at the other end)
//     undefined : rotate logic is not built and mode 10 acts as logical
//
// Parameters:
//   WIDTH  data word width (>= 2)
//   AMT_W  width of the shift-amount port
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   operation request, sampled only in IDLE
//   mode       in   [1:0] shift mode
//   dir        in   shift direction, 1 = left
//   din        in   serial fill bit (mode 11 only)
//   amt        in   [AMT_W-1:0] number of single-bit steps
//   I          in   [WIDTH-1:0] parallel load word
//   Q          out  [WIDTH-1:0] register contents
//   sout       out  last bit shifted or rotated out
//   busy       out  high while in SHIFT
//   done       out  one-cycle completion pulse
//   state_dbg  out  [1:0] FSM state: 0 IDLE, 1 SHIFT, 2 DONE
// ---------------------------------------------------------------------------
module shiftreg_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             din,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOGIC  = 2'b00;
  localparam logic [1:0] MODE_ARITH  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_SERIAL = 2'b11;

  state_t           state;
  logic [1:0]       mode_r;
  logic             dir_r;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH:0]   step_res;   // {exiting bit, next Q}

  assign state_dbg = state;

  // One single-bit step. The result is {bit shifted out, new word}.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] q,
    input logic [1:0]       m,
    input logic             left,
    input logic             serial_in
  );
    logic           fill;
    logic [WIDTH:0] r;
    fill = 1'b0;
    if (left) begin
      // Arithmetic left is the same as logical left, so it takes the default.
      case (m)
        MODE_SERIAL: fill = serial_in;
`ifdef SHIFTREG_ROTATE_EN
        MODE_ROTATE: fill = q[WIDTH-1];
`endif
        default:     fill = 1'b0;
      endcase
      r = {q[WIDTH-1], q[WIDTH-2:0], fill};
    end else begin
      case (m)
        MODE_ARITH:  fill = q[WIDTH-1];
        MODE_SERIAL: fill = serial_in;
`ifdef SHIFTREG_ROTATE_EN
        MODE_ROTATE: fill = q[0];
`endif
        default:     fill = 1'b0;
      endcase
      r = {q[0], fill, q[WIDTH-1:1]};
    end
    return r;
  endfunction

  always_comb begin
    step_res = shift_step(Q, mode_r, dir_r, din);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      Q      <= '0;
      sout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mode_r <= MODE_LOGIC;
      dir_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            Q      <= I;
            sout   <= 1'b0;
            mode_r <= mode;
            dir_r  <= dir;
            cnt    <= amt;
            // A zero amount skips SHIFT, so busy never rises.
            if (amt != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          {sout, Q} <= step_res;
          cnt       <= cnt - AMT_W'(1);
          // cnt == 1 means this edge does the final step.
          if (cnt == AMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_seq.sv
module tb_shiftreg_seq;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          dir;
  logic          din;
  logic [AW-1:0] amt;
  logic [W-1:0]  I;
  logic [W-1:0]  Q;
  logic          sout;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  int checks = 0;
  int passed = 0;

  // din values presented on each shift edge of the current operation.
  bit din_hist[$];

  shiftreg_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dir(dir), .din(din),
    .amt(amt), .I(I), .Q(Q), .sout(sout), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Whole-operation result computed arithmetically from the shift rules.
  function automatic void model(input logic [W-1:0] i, input logic [1:0] m,
                                input logic d, input int n,
                                output logic [W-1:0] q, output logic s);
    longint unsigned iv, x, r;
    longint sx;
    int k;
    logic [1:0] em;
    iv = 64'(i);
    em = m;
`ifndef SHIFTREG_ROTATE_EN
    if (m == 2'b10) em = 2'b00;
`endif
    q = i; s = 1'b0;
    if (n != 0) begin
      case (em)
        2'b00, 2'b01: begin
          if (d) begin
            x = iv << n;
            q = W'(x & 64'hFF); s = x[W];
          end else if (em == 2'b00) begin
            q = W'(iv >> n); r = iv >> (n - 1); s = r[0];
          end else begin
            sx = longint'(iv);
            if (i[W-1]) sx = sx | ~longint'(64'hFF);
            r = 64'(sx >>> n);       q = W'(r & 64'hFF);
            r = 64'(sx >>> (n - 1)); s = r[0];
          end
        end
        2'b10: begin
          k = n % W;
          if (d) begin
            r = ((iv << k) | (iv >> (W - k))) & 64'hFF;
            q = W'(r); s = r[0];
          end else begin
            r = ((iv >> k) | (iv << (W - k))) & 64'hFF;
            q = W'(r); s = r[W-1];
          end
        end
        default: begin
          if (d) begin
            x = iv;
            foreach (din_hist[j]) x = (x << 1) | 64'(din_hist[j]);
            q = W'(x & 64'hFF); s = x[W];
          end else begin
            // Fill bits stack above the word; the first one enters highest.
            x = iv;
            foreach (din_hist[j]) x = x | (64'(din_hist[j]) << (W + j));
            r = x >> n;       q = W'(r & 64'hFF);
            r = x >> (n - 1); s = r[0];
          end
        end
      endcase
    end
  endfunction

  // ---------------- driver ----------------
  // Issues one start, scrambles the request inputs after acceptance, drives
  // din during shifting, and measures the handshake timing.
  task automatic run_op(input logic [W-1:0] i, input logic [1:0] m, input logic d,
                        input logic [AW-1:0] a, input bit mid_start, input int din_sel,
                        output logic [W-1:0] q, output logic s, output int cyc,
                        output int bcnt, output logic dn_after,
                        output logic [W-1:0] q_after, output bit to);
    din_hist.delete();
    @(negedge clk);
    start = 1'b1; I = i; mode = m; dir = d; amt = a;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; I = W'($urandom); mode = 2'($urandom); dir = 1'($urandom);
    amt = AW'($urandom);
    cyc = 0; bcnt = 0; to = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) begin
        bcnt++;
        din = (din_sel < 0) ? 1'($urandom_range(0, 1)) : din_sel[0];
        din_hist.push_back(din);
        if (mid_start && bcnt == 2) begin
          start = 1'b1;
          I = ~i;
        end
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    q = Q; s = sout;
    @(posedge clk);
    @(negedge clk);
    dn_after = done; q_after = Q;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0; start = 1'b0; mode = 2'b00; dir = 1'b0; din = 1'b0;
    amt = '0; I = 8'hA5;
    #12;
    checks++; if (Q !== 8'h00) $display("FAIL reset_q got %h exp 00", Q); else passed++;
    checks++; if (sout !== 1'b0) $display("FAIL reset_sout got %b exp 0", sout); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_dbg); else passed++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_logical;
    logic [W-1:0] q, qa; logic s, dn; int cyc, bc; bit to;
    run_op(8'b1001_0110, 2'b00, 1'b0, 4'd3, 1'b0, -1, q, s, cyc, bc, dn, qa, to);
    checks++; if (to) $display("FAIL logical_timeout got no done exp done"); else passed++;
    checks++; if (q !== 8'b0001_0010) $display("FAIL logical_q got %b exp 00010010", q); else passed++;
    checks++; if (s !== 1'b1) $display("FAIL logical_sout got %b exp 1", s); else passed++;
    checks++; if (cyc !== 3) $display("FAIL logical_latency got %0d exp 3 edges to done", cyc); else passed++;
    checks++; if (bc !== 3) $display("FAIL logical_busy got %0d exp 3 cycles", bc); else passed++;
    checks++; if (dn !== 1'b0) $display("FAIL logical_done_width got %b exp 0", dn); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL logical_idle got %0d exp 0", state_dbg); else passed++;
  endtask

  task automatic test_arith;
    logic [W-1:0] q, qa; logic s, dn; int cyc, bc; bit to;
    run_op(8'b1001_0110, 2'b01, 1'b0, 4'd2, 1'b0, -1, q, s, cyc, bc, dn, qa, to);
    checks++; if (to) $display("FAIL arith_timeout got no done exp done"); else passed++;
    checks++; if (q !== 8'b1110_0101) $display("FAIL arith_q got %b exp 11100101", q); else passed++;
    checks++; if (s !== 1'b1) $display("FAIL arith_sout got %b exp 1", s); else passed++;
  endtask

  task automatic test_rotate;
    logic [W-1:0] q, qa, eq; logic s, dn, es; int cyc, bc; bit to;
    run_op(8'b1001_0110, 2'b10, 1'b1, 4'd3, 1'b0, -1, q, s, cyc, bc, dn, qa, to);
    model(8'b1001_0110, 2'b10, 1'b1, 3, eq, es);
`ifdef SHIFTREG_ROTATE_EN
    checks++; if (q !== 8'b1011_0100) $display("FAIL rotate_q got %b exp 10110100", q); else passed++;
`else
    checks++; if (q !== 8'b1011_0000) $display("FAIL rotate_q got %b exp 10110000", q); else passed++;
`endif
    checks++; if (s !== es) $display("FAIL rotate_sout got %b exp %b", s, es); else passed++;
    checks++; if (to) $display("FAIL rotate_timeout got no done exp done"); else passed++;
  endtask

  task automatic test_serial;
    logic [W-1:0] q, qa; logic s, dn; int cyc, bc; bit to;
    run_op(8'h00, 2'b11, 1'b0, 4'd4, 1'b0, 1, q, s, cyc, bc, dn, qa, to);
    checks++; if (q !== 8'b1111_0000) $display("FAIL serial_q got %b exp 11110000", q); else passed++;
    checks++; if (to) $display("FAIL serial_timeout got no done exp done"); else passed++;
  endtask

  task automatic test_zero_amt;
    @(negedge clk);
    start = 1'b1; I = 8'b0101_1010; mode = 2'b00; dir = 1'b0; amt = '0;
    @(posedge clk);
    @(negedge clk);
    // Keep start high with a different word: this second request lands in DONE.
    I = 8'hFF; amt = 4'd3;
    checks++; if (done !== 1'b1) $display("FAIL zero_done got %b exp 1", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL zero_busy got %b exp 0", busy); else passed++;
    checks++; if (Q !== 8'b0101_1010) $display("FAIL zero_q got %b exp 01011010", Q); else passed++;
    checks++; if (sout !== 1'b0) $display("FAIL zero_sout got %b exp 0", sout); else passed++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b0) $display("FAIL zero_done_clear got %b exp 0", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL zero_ignore_busy got %b exp 0", busy); else passed++;
    checks++; if (Q !== 8'b0101_1010) $display("FAIL zero_ignore_q got %b exp 01011010", Q); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL zero_ignore_state got %0d exp 0", state_dbg); else passed++;
  endtask

  task automatic test_start_in_shift;
    logic [W-1:0] q, qa, eq; logic s, dn, es; int cyc, bc; bit to;
    run_op(8'b1100_1011, 2'b00, 1'b1, 4'd5, 1'b1, -1, q, s, cyc, bc, dn, qa, to);
    model(8'b1100_1011, 2'b00, 1'b1, 5, eq, es);
    checks++; if (q !== eq) $display("FAIL midstart_q got %b exp %b", q, eq); else passed++;
    checks++; if (cyc !== 5) $display("FAIL midstart_latency got %0d exp 5", cyc); else passed++;
    checks++; if (dn !== 1'b0 || state_dbg !== 2'd0)
      $display("FAIL midstart_after got done=%b state=%0d exp done=0 state=0", dn, state_dbg);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] q, qa, eq; logic s, dn, es; int cyc, bc; bit to;
    @(negedge clk);
    start = 1'b1; I = 8'hB7; mode = 2'b00; dir = 1'b1; amt = 4'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (Q !== 8'h00) $display("FAIL rstmid_q got %h exp 00", Q); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rstmid_done got %b exp 0", done); else passed++;
    checks++; if (state_dbg !== 2'd0) $display("FAIL rstmid_state got %0d exp 0", state_dbg); else passed++;
    @(negedge clk);
    rst = 1'b1;
    run_op(8'h3C, 2'b00, 1'b1, 4'd1, 1'b0, -1, q, s, cyc, bc, dn, qa, to);
    model(8'h3C, 2'b00, 1'b1, 1, eq, es);
    checks++; if (q !== eq || to) $display("FAIL rstmid_restart got %b exp %b", q, eq); else passed++;
  endtask

  task automatic test_random;
    logic [W-1:0] i, q, qa, eq; logic [1:0] m; logic d, s, dn, es;
    logic [AW-1:0] a; int cyc, bc; bit to;
    for (int t = 0; t < 40; t++) begin
      i = W'($urandom); m = 2'($urandom_range(0, 3)); d = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 15));
      run_op(i, m, d, a, 1'b0, -1, q, s, cyc, bc, dn, qa, to);
      model(i, m, d, int'(a), eq, es);
      checks++; if (to) $display("FAIL rand_timeout t=%0d got no done exp done", t); else passed++;
      checks++; if (q !== eq) $display("FAIL rand_q t=%0d m=%0d d=%0d a=%0d i=%b got %b exp %b", t, m, d, a, i, q, eq); else passed++;
      checks++; if (s !== es) $display("FAIL rand_sout t=%0d m=%0d d=%0d a=%0d got %b exp %b", t, m, d, a, s, es); else passed++;
      checks++; if (cyc !== int'(a)) $display("FAIL rand_latency t=%0d got %0d exp %0d", t, cyc, a); else passed++;
      checks++; if (bc !== int'(a)) $display("FAIL rand_busy t=%0d got %0d exp %0d", t, bc, a); else passed++;
      checks++; if (dn !== 1'b0) $display("FAIL rand_done_width t=%0d got %b exp 0", t, dn); else passed++;
      checks++; if (qa !== eq) $display("FAIL rand_q_hold t=%0d got %b exp %b", t, qa, eq); else passed++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_rotate();
    test_serial();
    test_zero_amt();
    test_start_in_shift();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
